// File: rtl/id_ex_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_reg_if : bundle of the decode-side, execute-side and writeback
// signals of the ID/EX pipeline register.
//   slave  : view used by id_ex_reg itself
//   master : view used by whatever surrounds it (decode/execute/testbench)
// ---------------------------------------------------------------------------
interface id_ex_reg_if #(
   parameter int REG_WIDTH = 64
);

   // decode side
   logic                 in_valid;
   logic                 in_ready;
   logic [REG_WIDTH-1:0] in_rs1_data;
   logic [REG_WIDTH-1:0] in_rs2_data;
   logic [REG_WIDTH-1:0] in_imm;
   logic [4:0]           in_rs1;
   logic [4:0]           in_rs2;
   logic [4:0]           in_rd;
   logic                 in_alu_src;
   logic [3:0]           in_alu_control;
   logic                 in_reg_write;
   logic                 flush;

   // writeback forwarding source
   logic                 wb_reg_write;
   logic [4:0]           wb_rd;
   logic [REG_WIDTH-1:0] wb_data;

   // execute side
   logic                 out_valid;
   logic                 out_ready;
   logic [REG_WIDTH-1:0] alu_in1;
   logic [REG_WIDTH-1:0] alu_in2;
   logic [3:0]           alu_control;
   logic [4:0]           out_rd;
   logic                 out_reg_write;

   modport slave (
      input  in_valid, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd,
             in_alu_src, in_alu_control, in_reg_write, flush,
             wb_reg_write, wb_rd, wb_data, out_ready,
      output in_ready, out_valid, alu_in1, alu_in2, alu_control, out_rd,
             out_reg_write
   );

   modport master (
      output in_valid, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd,
             in_alu_src, in_alu_control, in_reg_write, flush,
             wb_reg_write, wb_rd, wb_data, out_ready,
      input  in_ready, out_valid, alu_in1, alu_in2, alu_control, out_rd,
             out_reg_write
   );

endinterface : id_ex_reg_if

// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg : ID/EX pipeline register built as a 2-entry skid buffer.
// The main register drives the ALU inputs directly; the skid register
// catches one extra entry when execute stalls, so in_ready can come from a
// flop (NOT skid_valid) with no combinational path from out_ready.
// Operand 2 is muxed (imm vs rs2) at capture time.
//
// Optional feature: define ID_EX_FWD_EN to forward wb_data into the rs1/rs2
// operand values at capture when writeback targets the same non-zero
// register. Without it the wb_* signals are ignored.
// ---------------------------------------------------------------------------
module id_ex_reg #(
   parameter int REG_WIDTH = 64
) (
   input logic         clk,
   input logic         reset_b,
   id_ex_reg_if.slave  bus
);

   typedef struct packed {
      logic [REG_WIDTH-1:0] op1;
      logic [REG_WIDTH-1:0] op2;
      logic [3:0]           ctl;
      logic [4:0]           rd;
      logic                 reg_write;
   } entry_t;

   entry_t               main_q;
   entry_t               skid_q;
   entry_t               cap;
   logic                 main_valid;
   logic                 skid_valid;
   logic                 in_ready;
   logic                 accept;
   logic                 consume;
   logic [REG_WIDTH-1:0] rs1_val;
   logic [REG_WIDTH-1:0] rs2_val;

   assign in_ready = ~skid_valid;
   assign accept   = bus.in_valid && in_ready;
   assign consume  = main_valid && bus.out_ready;

`ifndef ID_EX_FWD_EN
   // wb_* are intentionally unused when forwarding is compiled out.
   logic unused_wb;
   assign unused_wb = ^{bus.wb_reg_write, bus.wb_rd, bus.wb_data};
`endif

   // Build the entry to capture: operand values (optionally forwarded) and
   // the imm/rs2 select for operand 2.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      rs1_val = bus.in_rs1_data;
      rs2_val = bus.in_rs2_data;
`ifdef ID_EX_FWD_EN
      if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.in_rs1))
         rs1_val = bus.wb_data;
      if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.in_rs2))
         rs2_val = bus.wb_data;
`endif
      cap.op1       = rs1_val;
      cap.op2       = bus.in_alu_src ? bus.in_imm : rs2_val;
      cap.ctl       = bus.in_alu_control;
      cap.rd        = bus.in_rd;
      cap.reg_write = bus.in_reg_write;
   end

   // Skid-buffer state: reset beats flush beats the handshake.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop sees the pre-edge value of every other flop.
      if (!reset_b) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         // NOTE: the data registers are reset too because they drive the ALU
         // directly and must read zero out of reset.
         main_q     <= '0;
         skid_q     <= '0;
      end else if (bus.flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid || consume) begin
         // Main is free this edge: refill from skid first to keep FIFO order.
         // accept implies skid is empty, so the two sources never collide.
         if (skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
         end else if (accept) begin
            main_q     <= cap;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
         skid_valid <= 1'b0;
      end else if (accept) begin
         // Main is stalled: park the new entry in the skid register.
         skid_q     <= cap;
         skid_valid <= 1'b1;
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = main_valid;
   assign bus.alu_in1       = main_q.op1;
   assign bus.alu_in2       = main_q.op2;
   assign bus.alu_control   = main_q.ctl;
   assign bus.out_rd        = main_q.rd;
   assign bus.out_reg_write = main_q.reg_write;

endmodule : id_ex_reg

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
- REQ-001 SHALL have parameter: REG_WIDTH, default 64, width of operand and immediate data (equals register-file width).
- REQ-002 SHALL have one clock and one reset; reset is synchronous and active-low.
- REQ-003 SHALL have port: clk  input  1  rising-edge clock.
- REQ-004 SHALL have port: reset_b  input  1  synchronous active-low reset.
- REQ-005 SHALL have port: in_valid  input  1  decode stage offers an entry.
- REQ-006 SHALL have port: in_ready  output  1  stage can accept an entry.
- REQ-007 SHALL have ports: in_rs1_data, in_rs2_data, in_imm  input  REG_WIDTH  operands and sign-extended immediate.
- REQ-008 SHALL have ports: in_rs1, in_rs2, in_rd  input  5  source and destination register indices.
- REQ-009 SHALL have ports: in_alu_src  input  1  (1 selects in_imm for operand 2); in_alu_control  input  4; in_reg_write  input  1.
- REQ-010 SHALL have port: flush  input  1  discard all held and offered entries.
- REQ-011 SHALL have ports: wb_reg_write  input  1; wb_rd  input  5; wb_data  input  REG_WIDTH  writeback forwarding source.
- REQ-012 SHALL have ports: out_valid  output  1; out_ready  input  1  execute-side handshake.
- REQ-013 SHALL have ports: alu_in1, alu_in2  output  REG_WIDTH; alu_control  output  4; out_rd  output  5; out_reg_write  output  1; all registered, driving the ALU directly.

Function
- REQ-014 SHALL implement a 2-entry skid buffer: main register (drives outputs) and skid register.
- REQ-015 SHALL accept an entry on a clk edge where in_valid && in_ready; SHALL consume on out_valid && out_ready.
- REQ-016 SHALL drive in_ready from a flop, equal to NOT skid_valid; no combinational path from out_ready to in_ready.
- REQ-017 SHALL compute operand 2 at capture: in_alu_src ? in_imm : rs2 value; operand 1 is the rs1 value.
- REQ-018 SHALL present an accepted entry on outputs with out_valid=1 the cycle after acceptance when the main register is empty or being consumed (1-cycle latency).
- REQ-019 SHALL write an accepted entry into the skid register when the main register is valid and not consumed; skid moves to main when main is consumed.
- REQ-020 SHALL sustain one entry per cycle with out_ready held 1; order SHALL be strictly FIFO.
- REQ-021 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
- REQ-022 SHALL on flush=1 clear main and skid valid at that edge, drop any simultaneous input, and set in_ready=1 next cycle.
- REQ-023 SHALL apply priority reset_b > flush > handshake.
- REQ-024 SHALL pass in_alu_control, in_rd, in_reg_write through unchanged with the entry.

Reset
- REQ-025 SHALL when reset_b=0 at a clk edge set out_valid=0, skid empty, in_ready=1, alu_in1=alu_in2=0, alu_control=4'b0000, out_rd=0, out_reg_write=0.
- REQ-026 SHALL discard in-flight entries on reset mid-transfer; no entry leaks out after reset release.

Configuration
- REQ-027 SHALL gate writeback forwarding with macro ID_EX_FWD_EN.
- REQ-028 With ID_EX_FWD_EN defined: at capture, if wb_reg_write && wb_rd!=0 && wb_rd==in_rs1, rs1 value SHALL be wb_data; same rule independently for in_rs2 (before alu_src mux).
- REQ-029 Without ID_EX_FWD_EN: wb_* ports SHALL exist but be ignored; register data used as given.

Verification
- REQ-030 Reset: reset_b=0 two cycles with in_valid=1 -> out_valid=0, in_ready=1, all data outputs 0.
- REQ-031 Streaming: rs1=8, rs2=4, alu_control 0010/0110/0000/0001 back-to-back, out_ready=1 -> four entries, one per cycle, 1-cycle latency, alu_in1=8, alu_in2=4, order kept.
- REQ-032 Backpressure: out_ready=0 while three entries offered -> two accepted, in_ready=0 after second, outputs frozen on first; out_ready=1 -> both drain in order, in_ready=1.
- REQ-033 Immediate select: rs2=4, imm=-1, alu_src=1 -> alu_in2=64'hFFFF_FFFF_FFFF_FFFF.
- REQ-034 Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, no flushed entry ever appears.
- REQ-035 ID_EX_FWD_EN: in_rs1=5, in_rs1_data=8, wb_reg_write=1, wb_rd=5, wb_data=100 -> alu_in1=100; wb_rd=0 -> alu_in1=8; without macro -> alu_in1=8.
